arbiter_mux_bus: RTL and testbench

Round-robin N-to-1 bus multiplexer with valid/ready handshakes: the gather-side counterpart of the engine's demux fan-out. It collects beats from BUS_WIDTH source channels onto one registered output channel, at up to one beat per cycle. It tags each beat with its source index in `sel_out`, so responses can later be routed back to the originating channel.

---
 rtl/arbiter_mux_bus_if.sv | 26 ++
 rtl/arbiter_mux_bus.sv | 75 +++++++
 tb/tb_arbiter_mux_bus.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/arbiter_mux_bus_if.sv
// Gather-bus bundle: BUS_WIDTH source channels in, one tagged output channel out.
interface arbiter_mux_bus_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 8,
  parameter int SEL_WIDTH  = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1
);
  logic [DATA_WIDTH-1:0] data_in [BUS_WIDTH-1:0];
  logic [BUS_WIDTH-1:0]  data_in_valid;
  logic [BUS_WIDTH-1:0]  data_in_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic [SEL_WIDTH-1:0]  sel_out;

  // Arbiter side.
  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid, sel_out
  );

  // Sources plus downstream consumer side.
  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid, sel_out
  );
endinterface

// File: rtl/arbiter_mux_bus.sv
// Round-robin N-to-1 bus multiplexer with a registered, source-tagged output.
module arbiter_mux_bus #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 8,
  parameter int SEL_WIDTH  = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1
) (
  input  logic              ap_clk,
  input  logic              areset,
  arbiter_mux_bus_if.slave  bus
);

  logic [SEL_WIDTH-1:0]  r_ptr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic                  r_valid;

  logic                  w_can_load;
  logic                  w_any;
  logic [BUS_WIDTH-1:0]  w_grant;
  logic [SEL_WIDTH-1:0]  w_gidx;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_accept;
  logic                  w_pop;

  assign w_can_load = !r_valid || bus.data_out_ready;
  assign w_accept   = w_any && w_can_load && !areset;
  assign w_pop      = r_valid && bus.data_out_ready;

  // First valid channel searching upward from r_ptr with wrap; also selects its data.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_data  = '0;
    w_any   = 1'b0;
    for (int unsigned k = 0; k < BUS_WIDTH; k++) begin
      int unsigned idx;
      idx = 32'(r_ptr) + k;
      if (idx >= BUS_WIDTH) idx = idx - BUS_WIDTH;
      if (!w_any && bus.data_in_valid[idx]) begin
        w_any        = 1'b1;
        w_grant[idx] = 1'b1;
        w_gidx       = SEL_WIDTH'(idx);
        w_data       = bus.data_in[idx];
      end
    end
  end

  // Ready only to the granted channel, and only when the output register can take it.
  always_comb begin
    bus.data_in_ready = '0;
    if (!areset) bus.data_in_ready = w_grant & {BUS_WIDTH{w_can_load}};
  end

  // Output register and priority pointer; accept wins over pop to keep full throughput.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_data;
      r_sel   <= w_gidx;
      r_ptr   <= (32'(w_gidx) == BUS_WIDTH - 1) ? '0 : w_gidx + 1'b1;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.data_out       = r_data;
  assign bus.data_out_valid = r_valid;
  assign bus.sel_out        = r_sel;

endmodule

// File: tb/tb_arbiter_mux_bus.sv
// Directed self-checking bench: 8-channel and 5-channel instances.
module tb_arbiter_mux_bus;

  logic ap_clk = 1'b0;
  logic rst_a  = 1'b1;
  logic rst_b  = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 ap_clk = ~ap_clk;

  arbiter_mux_bus_if #(.DATA_WIDTH(32), .BUS_WIDTH(8)) bus_a ();
  arbiter_mux_bus_if #(.DATA_WIDTH(32), .BUS_WIDTH(5)) bus_b ();

  arbiter_mux_bus #(.DATA_WIDTH(32), .BUS_WIDTH(8)) u_dut_a (
    .ap_clk (ap_clk),
    .areset (rst_a),
    .bus    (bus_a.slave)
  );

  arbiter_mux_bus #(.DATA_WIDTH(32), .BUS_WIDTH(5)) u_dut_b (
    .ap_clk (ap_clk),
    .areset (rst_b),
    .bus    (bus_b.slave)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance past the next active edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) bus_a.data_in[i] = '0;
    for (int i = 0; i < 5; i++) bus_b.data_in[i] = '0;
    bus_a.data_in_valid  = '0;
    bus_a.data_out_ready = 1'b1;
    bus_b.data_in_valid  = '0;
    bus_b.data_out_ready = 1'b1;

    // Reset state, with sources requesting so ready gating is exercised.
    bus_a.data_in_valid = 8'hFF;
    tick(); tick();
    chk("rst_valid", 64'(bus_a.data_out_valid), 64'd0);
    chk("rst_data",  64'(bus_a.data_out), 64'd0);
    chk("rst_sel",   64'(bus_a.sel_out), 64'd0);
    chk("rst_ready", 64'(bus_a.data_in_ready), 64'h00);
    bus_a.data_in_valid = '0;

    // Single channel 5.
    rst_a = 1'b0;
    tick();
    bus_a.data_in[5]    = 32'hA5A5_0005;
    bus_a.data_in_valid = 8'h20;
    #1;
    chk("single_ready", 64'(bus_a.data_in_ready), 64'h20);
    tick();
    bus_a.data_in_valid = '0;
    chk("single_data",  64'(bus_a.data_out), 64'hA5A5_0005);
    chk("single_sel",   64'(bus_a.sel_out), 64'd5);
    chk("single_valid", 64'(bus_a.data_out_valid), 64'd1);
    bus_a.data_in_valid = 8'hFF;
    #1;
    chk("single_ptr6", 64'(bus_a.data_in_ready), 64'h40);
    bus_a.data_in_valid = '0;
    tick();
    chk("pop_valid", 64'(bus_a.data_out_valid), 64'd0);
    chk("pop_hold_sel", 64'(bus_a.sel_out), 64'd5);

    // All-valid round robin from reset.
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    for (int i = 0; i < 8; i++) bus_a.data_in[i] = 32'h100 + 32'(i);
    bus_a.data_in_valid = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("rr_valid", 64'(bus_a.data_out_valid), 64'd1);
      chk("rr_sel",   64'(bus_a.sel_out), 64'(c % 8));
      chk("rr_data",  64'(bus_a.data_out), 64'h100 + 64'(c % 8));
    end

    // Reset mid-stream with output full and all channels valid.
    rst_a = 1'b1;
    #1;
    chk("midrst_ready_comb", 64'(bus_a.data_in_ready), 64'h00);
    tick();
    chk("midrst_valid", 64'(bus_a.data_out_valid), 64'd0);
    chk("midrst_data",  64'(bus_a.data_out), 64'd0);
    chk("midrst_sel",   64'(bus_a.sel_out), 64'd0);
    chk("midrst_ready", 64'(bus_a.data_in_ready), 64'h00);
    rst_a = 1'b0;
    #1;
    chk("postrst_ready", 64'(bus_a.data_in_ready), 64'h01);
    tick();
    chk("postrst_sel",  64'(bus_a.sel_out), 64'd0);
    chk("postrst_data", 64'(bus_a.data_out), 64'h100);

    // Backpressure: channels 2 and 6, ptr back to 0.
    bus_a.data_in_valid = '0;
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    bus_a.data_in[2]     = 32'hBEEF_0002;
    bus_a.data_in[6]     = 32'hBEEF_0006;
    bus_a.data_in_valid  = 8'h44;
    bus_a.data_out_ready = 1'b1;
    #1;
    chk("bp_first_ready", 64'(bus_a.data_in_ready), 64'h04);
    tick();
    bus_a.data_in_valid  = 8'h40;
    bus_a.data_out_ready = 1'b0;
    #1;
    chk("bp_sel0",   64'(bus_a.sel_out), 64'd2);
    chk("bp_ready0", 64'(bus_a.data_in_ready), 64'h00);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_hold_sel",   64'(bus_a.sel_out), 64'd2);
      chk("bp_hold_data",  64'(bus_a.data_out), 64'hBEEF_0002);
      chk("bp_hold_valid", 64'(bus_a.data_out_valid), 64'd1);
      chk("bp_hold_ready", 64'(bus_a.data_in_ready), 64'h00);
    end
    bus_a.data_out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus_a.data_in_ready), 64'h40);
    tick();
    bus_a.data_in_valid = '0;
    chk("bp_sel6",   64'(bus_a.sel_out), 64'd6);
    chk("bp_data6",  64'(bus_a.data_out), 64'hBEEF_0006);
    chk("bp_valid6", 64'(bus_a.data_out_valid), 64'd1);

    // Wrap and skip: ptr is now 7, channels 1 and 7 valid.
    bus_a.data_in[1]    = 32'hCAFE_0001;
    bus_a.data_in[7]    = 32'hCAFE_0007;
    bus_a.data_in_valid = 8'h82;
    #1;
    chk("wrap_ready7", 64'(bus_a.data_in_ready), 64'h80);
    tick();
    bus_a.data_in_valid = 8'h02;
    chk("wrap_sel7", 64'(bus_a.sel_out), 64'd7);
    #1;
    chk("wrap_ready1", 64'(bus_a.data_in_ready), 64'h02);
    tick();
    bus_a.data_in_valid = '0;
    chk("wrap_sel1",  64'(bus_a.sel_out), 64'd1);
    chk("wrap_data1", 64'(bus_a.data_out), 64'hCAFE_0001);
    bus_a.data_in_valid = 8'hFF;
    #1;
    chk("wrap_ptr2", 64'(bus_a.data_in_ready), 64'h04);
    bus_a.data_in_valid = '0;
    tick();

    // Non-power-of-two instance: 5 channels, all valid.
    chk("b_rst_valid", 64'(bus_b.data_out_valid), 64'd0);
    for (int i = 0; i < 5; i++) bus_b.data_in[i] = 32'h50 + 32'(i);
    bus_b.data_in_valid = 5'h1F;
    rst_b = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("b_sel",  64'(bus_b.sel_out), 64'(c % 5));
      chk("b_data", 64'(bus_b.data_out), 64'h50 + 64'(c % 5));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
